mem_port_arb: RTL and testbench
===============================

MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter PROG_HOLD, 4, number of idle cycles the programmer keeps port ownership after its last write (1..15).
REQ-002 Parameter IO_BASE_NIB, 4'h1, value of addr[31:28] that selects the IO region.
REQ-003 CLK  in  1  the single clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 cpu_rd  in  1  memory-stage load request.
REQ-006 cpu_wr  in  1  memory-stage store request.
REQ-007 cpu_addr  in  32  memory-stage byte address.
REQ-008 cpu_din  in  32  store data.
REQ-009 cpu_size  in  2  access size: 00 byte, 01 half, 10 word.
REQ-010 cpu_sign  in  1  1 = zero-extend load (func3[2]).
REQ-011 prg_we  in  1  programmer word write strobe.
REQ-012 prg_addr  in  32  programmer address.
REQ-013 prg_data  in  32  programmer data.
REQ-014 mem_addr2, mem_din2  out  32 each  memory port-2 address and write data.
REQ-015 mem_size, mem_sign, mem_read2, mem_write2  out  2/1/1/1  memory port-2 controls.
REQ-016 cpu_stall  out  1  pipeline must hold the memory stage and everything before it.
REQ-017 cpu_rvalid  out  1  port-2 read data valid for the CPU this cycle.
REQ-018 prog_active  out  1  programmer owns port 2.

Function
REQ-019 The FSM SHALL have the states IDLE, PROG and IO_WAIT.
REQ-020 IDLE, prg_we=1: programmer muxed to the port, mem_write2=1, mem_size=10, mem_sign=0, cpu_stall=1, counter loaded with PROG_HOLD, next state PROG. This holds even when a CPU request is present in the same cycle.
REQ-021 IDLE, no prg_we, cpu_wr=1: CPU fields muxed to the port, mem_write2=1, no stall, write completes in that cycle.
REQ-022 IDLE, cpu_rd=1 and cpu_wr=0, non-IO address: mem_read2=1, no stall, cpu_rvalid=1 exactly one cycle later.
REQ-023 cpu_rd and cpu_wr both high: treated as a write only; no read is issued and cpu_rvalid is not asserted.
REQ-024 PROG: cpu_stall=1 and prog_active=1 in every cycle; each prg_we performs a write and reloads the counter to PROG_HOLD; a cycle without prg_we decrements the counter; the state moves to IDLE in the cycle after the counter reaches 0.
REQ-025 While in PROG, mem_read2 and all CPU-sourced writes SHALL be 0.
REQ-026 A CPU read already issued when prg_we arrives SHALL still produce its cpu_rvalid pulse on schedule.
REQ-027 Outside any active access, port outputs SHALL be 0 (address, data, controls).
REQ-028 cpu_rvalid is a one-cycle pulse; it is never asserted two cycles in a row for a single read.

Reset
REQ-029 When RST=1 at a clock edge: state IDLE, counter 0, pending rvalid cleared, all outputs 0 on the following cycle.
REQ-030 RST during PROG or IO_WAIT SHALL abort the state without issuing a further memory access.

Configuration
REQ-031 Macro MEM_ARB_IO_WAIT_EN defined: a CPU read with addr[31:28]==IO_BASE_NIB issues mem_read2 and asserts cpu_stall in the issue cycle, enters IO_WAIT for one cycle with the stall still asserted, then returns to IDLE; cpu_rvalid is asserted 2 cycles after the issue cycle.
REQ-032 Macro undefined: IO reads behave exactly as in REQ-022, and IO_WAIT is never entered.

Structure
REQ-033 The state enum, the size codes (BYTE/HALF/WORD) and the IO_BASE default SHALL live in a shared package, otter_mem_pkg.
REQ-034 The programmer hold counter SHALL be implemented as a single sub-module, prog_hold_cnt (load, decrement, zero flag).

Verification
REQ-035 cpu_rd, addr 0x0000_0100, word -> mem_read2=1 that cycle, cpu_rvalid=1 next cycle, cpu_stall stays 0.
REQ-036 prg_we with addr 0x40 and data 0xDEADBEEF in the same cycle as cpu_wr to 0x80 -> port carries 0x40/0xDEADBEEF with size 10, cpu_stall=1, and no write to 0x80 occurs until PROG exits.
REQ-037 Three prg_we one cycle apart, then idle, with PROG_HOLD=4 -> prog_active stays high for 4 cycles after the last write, then IDLE; the pending CPU store completes in the first IDLE cycle.
REQ-038 With MEM_ARB_IO_WAIT_EN defined, cpu_rd to 0x1100_0000 -> cpu_stall high for 2 cycles, cpu_rvalid at issue+2; with the macro undefined -> no stall, cpu_rvalid at issue+1.
REQ-039 RST asserted in the second PROG cycle -> the next cycle shows state IDLE, all outputs 0, and no spurious cpu_rvalid.
REQ-040 cpu_rd and cpu_wr both high to 0x200 -> a single write occurs and cpu_rvalid is never asserted.

Source files
------------

// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the memory port-2 arbiter.
package otter_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROG    = 2'd1,
        ST_IO_WAIT = 2'd2
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] IO_BASE_NIB_DEF = 4'h1;
    localparam int unsigned HOLD_W = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] din;
        logic [1:0]  size;
        logic        sign;
        logic        rd;
        logic        wr;
    } port_t;

    localparam port_t PORT_IDLE = '0;

endpackage

// File: rtl/prog_hold_cnt.sv
// Programmer ownership hold counter: load to HOLD, decrement, zero flag.
module prog_hold_cnt
    import otter_mem_pkg::*;
#(
    parameter logic [HOLD_W-1:0] HOLD = 4'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              dec,
    output logic [HOLD_W-1:0] cnt,
    output logic              zero
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = HOLD;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates memory port 2 between the CPU memory stage and the programmer.
// Define MEM_ARB_IO_WAIT_EN to add a one-cycle wait state on IO-region reads.
module mem_port_arb
    import otter_mem_pkg::*;
#(
    parameter int unsigned PROG_HOLD   = 4,
    parameter logic [3:0]  IO_BASE_NIB = IO_BASE_NIB_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    input  logic        prg_we,
    input  logic [31:0] prg_addr,
    input  logic [31:0] prg_data,
    output logic [31:0] mem_addr2,
    output logic [31:0] mem_din2,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    output logic        mem_read2,
    output logic        mem_write2,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic        prog_active
);

`ifdef MEM_ARB_IO_WAIT_EN
    localparam bit IO_WAIT_EN = 1'b1;
`else
    localparam bit IO_WAIT_EN = 1'b0;
`endif

    arb_state_e state_q, state_d;
    logic       rd_pend_q, rd_pend_d;

    logic              cnt_load;
    logic              cnt_dec;
    logic [HOLD_W-1:0] cnt;
    logic              cnt_zero;

    port_t port;
    logic  stall;
    logic  owner_prg;
    logic  io_wait_rd;

    prog_hold_cnt #(
        .HOLD (HOLD_W'(PROG_HOLD))
    ) u_hold_cnt (
        .clk  (CLK),
        .rst  (RST),
        .load (cnt_load),
        .dec  (cnt_dec),
        .cnt  (cnt),
        .zero (cnt_zero)
    );

    assign io_wait_rd = IO_WAIT_EN && (cpu_addr[31:28] == IO_BASE_NIB);

    always_comb begin
        state_d   = state_q;
        rd_pend_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        port      = PORT_IDLE;
        stall     = 1'b0;
        owner_prg = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (prg_we) begin
                    port      = '{addr: prg_addr, din: prg_data, size: SIZE_WORD,
                                  sign: 1'b0, rd: 1'b0, wr: 1'b1};
                    stall     = 1'b1;
                    owner_prg = 1'b1;
                    cnt_load  = 1'b1;
                    state_d   = ST_PROG;
                end else if (cpu_wr) begin
                    port = '{addr: cpu_addr, din: cpu_din, size: cpu_size,
                             sign: cpu_sign, rd: 1'b0, wr: 1'b1};
                end else if (cpu_rd) begin
                    port = '{addr: cpu_addr, din: 32'h0, size: cpu_size,
                             sign: cpu_sign, rd: 1'b1, wr: 1'b0};
                    if (io_wait_rd) begin
                        stall   = 1'b1;
                        state_d = ST_IO_WAIT;
                    end else begin
                        rd_pend_d = 1'b1;
                    end
                end
            end
            ST_PROG: begin
                stall     = 1'b1;
                owner_prg = 1'b1;
                if (prg_we) begin
                    port     = '{addr: prg_addr, din: prg_data, size: SIZE_WORD,
                                 sign: 1'b0, rd: 1'b0, wr: 1'b1};
                    cnt_load = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    // Leave as the counter steps from 1 to 0 so ownership lasts PROG_HOLD idle cycles.
                    if (cnt_zero || (cnt == HOLD_W'(1))) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IO_WAIT: begin
                stall     = 1'b1;
                rd_pend_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Reset masks everything so an aborted PROG/IO_WAIT cannot leak an access.
    always_comb begin
        if (RST) begin
            mem_addr2   = 32'h0;
            mem_din2    = 32'h0;
            mem_size    = 2'b00;
            mem_sign    = 1'b0;
            mem_read2   = 1'b0;
            mem_write2  = 1'b0;
            cpu_stall   = 1'b0;
            cpu_rvalid  = 1'b0;
            prog_active = 1'b0;
        end else begin
            mem_addr2   = port.addr;
            mem_din2    = port.din;
            mem_size    = port.size;
            mem_sign    = port.sign;
            mem_read2   = port.rd;
            mem_write2  = port.wr;
            cpu_stall   = stall;
            cpu_rvalid  = rd_pend_q;
            prog_active = owner_prg;
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed self-checking bench for mem_port_arb (PROG_HOLD = 4).
module tb_mem_port_arb;

    logic        CLK;
    logic        RST;
    logic        cpu_rd, cpu_wr, cpu_sign, prg_we;
    logic [31:0] cpu_addr, cpu_din, prg_addr, prg_data;
    logic [1:0]  cpu_size;
    logic [31:0] mem_addr2, mem_din2;
    logic [1:0]  mem_size;
    logic        mem_sign, mem_read2, mem_write2;
    logic        cpu_stall, cpu_rvalid, prog_active;

    int total = 0;
    int bad   = 0;

    mem_port_arb #(.PROG_HOLD(4), .IO_BASE_NIB(4'h1)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_size    (cpu_size),
        .cpu_sign    (cpu_sign),
        .prg_we      (prg_we),
        .prg_addr    (prg_addr),
        .prg_data    (prg_data),
        .mem_addr2   (mem_addr2),
        .mem_din2    (mem_din2),
        .mem_size    (mem_size),
        .mem_sign    (mem_sign),
        .mem_read2   (mem_read2),
        .mem_write2  (mem_write2),
        .cpu_stall   (cpu_stall),
        .cpu_rvalid  (cpu_rvalid),
        .prog_active (prog_active)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_port_zero(input string tag);
        chk({tag, "_addr"},  mem_addr2, 32'h0);
        chk({tag, "_din"},   mem_din2, 32'h0);
        chk({tag, "_size"},  {30'h0, mem_size}, 32'h0);
        chk({tag, "_sign"},  {31'h0, mem_sign}, 32'h0);
        chk({tag, "_read"},  {31'h0, mem_read2}, 32'h0);
        chk({tag, "_write"}, {31'h0, mem_write2}, 32'h0);
    endtask

    task automatic idle_in();
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_sign = 1'b0; cpu_size = 2'b00;
        cpu_addr = 32'h0; cpu_din = 32'h0;
        prg_we = 1'b0; prg_addr = 32'h0; prg_data = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    initial begin
        RST = 1'b1;
        idle_in();
        next_cycle();
        next_cycle();
        look();
        chk_port_zero("rst_hold");
        chk("rst_hold_rvalid", cpu_rvalid, 0);

        RST = 1'b0;
        look();
        chk_port_zero("post_rst");
        chk("post_rst_stall", cpu_stall, 0);
        chk("post_rst_prog", prog_active, 0);
        chk("post_rst_rvalid", cpu_rvalid, 0);
        next_cycle();

        // Plain word read: issue now, data valid next cycle.
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0100; cpu_size = 2'b10;
        look();
        chk("rd_read2", mem_read2, 1);
        chk("rd_addr", mem_addr2, 32'h100);
        chk("rd_size", mem_size, 2'b10);
        chk("rd_stall", cpu_stall, 0);
        chk("rd_rvalid_early", cpu_rvalid, 0);
        chk("rd_write2", mem_write2, 0);
        next_cycle();
        idle_in();
        look();
        chk("rd_rvalid", cpu_rvalid, 1);
        chk("rd_read2_off", mem_read2, 0);
        chk("rd_stall_after", cpu_stall, 0);
        next_cycle();
        look();
        chk("rd_rvalid_pulse", cpu_rvalid, 0);

        // Byte read, zero-extend flag passes through.
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0105; cpu_size = 2'b00; cpu_sign = 1'b1;
        look();
        chk("rdb_size", mem_size, 2'b00);
        chk("rdb_sign", mem_sign, 1);
        chk("rdb_addr", mem_addr2, 32'h105);
        next_cycle();
        idle_in();
        look();
        chk("rdb_rvalid", cpu_rvalid, 1);
        next_cycle();

        // CPU halfword store completes in its own cycle.
        cpu_wr = 1'b1; cpu_addr = 32'h84; cpu_din = 32'h1234_5678; cpu_size = 2'b01;
        look();
        chk("wr_write2", mem_write2, 1);
        chk("wr_read2", mem_read2, 0);
        chk("wr_addr", mem_addr2, 32'h84);
        chk("wr_din", mem_din2, 32'h1234_5678);
        chk("wr_size", mem_size, 2'b01);
        chk("wr_stall", cpu_stall, 0);
        next_cycle();
        idle_in();
        look();
        chk("wr_no_rvalid", cpu_rvalid, 0);
        chk("wr_write_off", mem_write2, 0);
        next_cycle();

        // Read and write together count as a write only.
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h200; cpu_din = 32'hA5A5_A5A5; cpu_size = 2'b10;
        look();
        chk("rw_write2", mem_write2, 1);
        chk("rw_read2", mem_read2, 0);
        chk("rw_addr", mem_addr2, 32'h200);
        next_cycle();
        idle_in();
        look();
        chk("rw_rvalid1", cpu_rvalid, 0);
        next_cycle();
        look();
        chk("rw_rvalid2", cpu_rvalid, 0);

        // Programmer beats a simultaneous CPU store; three writes then hold.
        prg_we = 1'b1; prg_addr = 32'h40; prg_data = 32'hDEAD_BEEF;
        cpu_wr = 1'b1; cpu_addr = 32'h80; cpu_din = 32'h55; cpu_size = 2'b10;
        look();
        chk("pw0_addr", mem_addr2, 32'h40);
        chk("pw0_din", mem_din2, 32'hDEAD_BEEF);
        chk("pw0_size", mem_size, 2'b10);
        chk("pw0_sign", mem_sign, 0);
        chk("pw0_write", mem_write2, 1);
        chk("pw0_stall", cpu_stall, 1);
        next_cycle();
        prg_addr = 32'h44; prg_data = 32'h1;
        look();
        chk("pw1_prog", prog_active, 1);
        chk("pw1_stall", cpu_stall, 1);
        chk("pw1_addr", mem_addr2, 32'h44);
        chk("pw1_write", mem_write2, 1);
        next_cycle();
        prg_addr = 32'h48; prg_data = 32'h2;
        look();
        chk("pw2_addr", mem_addr2, 32'h48);
        chk("pw2_din", mem_din2, 32'h2);
        next_cycle();
        prg_we = 1'b0; prg_addr = 32'h0; prg_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            look();
            chk($sformatf("hold%0d_prog", i), prog_active, 1);
            chk($sformatf("hold%0d_stall", i), cpu_stall, 1);
            chk($sformatf("hold%0d_write", i), mem_write2, 0);
            chk($sformatf("hold%0d_read", i), mem_read2, 0);
            chk($sformatf("hold%0d_addr", i), mem_addr2, 32'h0);
            next_cycle();
        end
        look();
        chk("exit_prog", prog_active, 0);
        chk("exit_stall", cpu_stall, 0);
        chk("exit_cpu_write", mem_write2, 1);
        chk("exit_cpu_addr", mem_addr2, 32'h80);
        chk("exit_cpu_din", mem_din2, 32'h55);
        next_cycle();
        idle_in();

        // An issued read still returns its pulse when the programmer takes over.
        cpu_rd = 1'b1; cpu_addr = 32'h108; cpu_size = 2'b10;
        look();
        chk("ovl_read2", mem_read2, 1);
        next_cycle();
        cpu_rd = 1'b0; cpu_addr = 32'h0;
        prg_we = 1'b1; prg_addr = 32'h60; prg_data = 32'h77;
        look();
        chk("ovl_rvalid", cpu_rvalid, 1);
        chk("ovl_write", mem_write2, 1);
        chk("ovl_stall", cpu_stall, 1);
        chk("ovl_addr", mem_addr2, 32'h60);
        next_cycle();
        idle_in();
        look();
        chk("ovl_rvalid_pulse", cpu_rvalid, 0);
        chk("ovl_prog", prog_active, 1);
        repeat (4) next_cycle();
        look();
        chk("ovl_exit_prog", prog_active, 0);

        // IO-region read.
        cpu_rd = 1'b1; cpu_addr = 32'h1100_0000; cpu_size = 2'b10;
        look();
        chk("io_read2", mem_read2, 1);
`ifdef MEM_ARB_IO_WAIT_EN
        chk("io_stall0", cpu_stall, 1);
`else
        chk("io_stall0", cpu_stall, 0);
`endif
        next_cycle();
        idle_in();
        look();
        chk("io_read2_off", mem_read2, 0);
`ifdef MEM_ARB_IO_WAIT_EN
        chk("io_stall1", cpu_stall, 1);
        chk("io_rvalid1", cpu_rvalid, 0);
`else
        chk("io_stall1", cpu_stall, 0);
        chk("io_rvalid1", cpu_rvalid, 1);
`endif
        next_cycle();
        look();
        chk("io_stall2", cpu_stall, 0);
`ifdef MEM_ARB_IO_WAIT_EN
        chk("io_rvalid2", cpu_rvalid, 1);
`else
        chk("io_rvalid2", cpu_rvalid, 0);
`endif
        next_cycle();

        // Reset in the second PROG cycle aborts ownership.
        prg_we = 1'b1; prg_addr = 32'h70; prg_data = 32'h99;
        look();
        chk("rp_stall", cpu_stall, 1);
        next_cycle();
        prg_we = 1'b0;
        look();
        chk("rp_prog1", prog_active, 1);
        next_cycle();
        RST = 1'b1; prg_we = 1'b1; prg_addr = 32'h74;
        look();
        chk("rp_rst_write", mem_write2, 0);
        next_cycle();
        RST = 1'b0;
        idle_in();
        look();
        chk_port_zero("rp_after");
        chk("rp_after_prog", prog_active, 0);
        chk("rp_after_stall", cpu_stall, 0);
        chk("rp_after_rvalid", cpu_rvalid, 0);
        cpu_wr = 1'b1; cpu_addr = 32'h90; cpu_din = 32'h3; cpu_size = 2'b10;
        look();
        chk("rp_idle_write", mem_write2, 1);
        chk("rp_idle_stall", cpu_stall, 0);
        next_cycle();
        idle_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
